// File: rtl/click_classifier_if.sv
// click_classifier_if: groups the press input and the classification outputs.
//   press        : debounced press pulse, one clk wide (master -> slave)
//   single_click : one-cycle single-click event        (slave -> master)
//   double_click : one-cycle double-click event        (slave -> master)
//   mode         : current wrap-around mode index      (slave -> master)
//   busy         : classifier is not idle              (slave -> master)
interface click_classifier_if #(
   parameter int MODE_W = 2
);
   logic              press;
   logic              single_click;
   logic              double_click;
   logic [MODE_W-1:0] mode;
   logic              busy;

   modport master (output press, input single_click, double_click, mode, busy);
   modport slave  (input press, output single_click, double_click, mode, busy);
endinterface

// File: rtl/click_classifier.sv
// click_classifier: classifies debounced presses as single or double clicks
// using a WINDOW-cycle window after the first press, and keeps a mode index
// that single clicks advance (wrapping) and double clicks clear.
//   clk  : system clock
//   rst  : asynchronous reset, active low
//   bus  : slave side of click_classifier_if (press in; events, mode, busy out)
module click_classifier #(
   parameter int WINDOW    = 5000000,
   parameter int NUM_MODES = 4,
   parameter int MODE_W    = 2
) (
   input  logic               clk,
   input  logic               rst,
   click_classifier_if.slave  bus
);
   localparam int              CNT_W     = $clog2(WINDOW);
   localparam logic [CNT_W-1:0]  WIN_LAST  = CNT_W'(WINDOW - 1);
   localparam logic [MODE_W-1:0] MODE_LAST = MODE_W'(NUM_MODES - 1);

   typedef enum logic [1:0] {IDLE, WAIT, SINGLE, DOUBLE} state_t;

   state_t            r_state;
   state_t            w_next;
   logic [CNT_W-1:0]  r_cnt;
   logic [MODE_W-1:0] r_mode;
   logic              w_timeout;

   assign w_timeout = (r_cnt == WIN_LAST);

   // state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= IDLE;
      else      r_state <= w_next;
   end

   // next-state logic; a press in WAIT wins over a same-cycle timeout
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (bus.press) w_next = WAIT;
         WAIT: begin
            if (bus.press)      w_next = DOUBLE;
            else if (w_timeout) w_next = SINGLE;
         end
         SINGLE:  w_next = IDLE;
         DOUBLE:  w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // window counter: cleared on the first press, only meaningful in WAIT
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt <= '0;
      end else if (r_state == IDLE && bus.press) begin
         r_cnt <= '0;
      end else if (r_state == WAIT && !bus.press && !w_timeout) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // mode changes on the edge entering SINGLE/DOUBLE so it lines up with the pulse
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_mode <= '0;
      end else if (r_state == WAIT && w_next == DOUBLE) begin
         r_mode <= '0;
      end else if (r_state == WAIT && w_next == SINGLE) begin
         r_mode <= (r_mode == MODE_LAST) ? '0 : r_mode + 1'b1;
      end
   end

   // Moore outputs
   always_comb begin
      bus.single_click = (r_state == SINGLE);
      bus.double_click = (r_state == DOUBLE);
      bus.busy         = (r_state != IDLE);
      bus.mode         = r_mode;
   end
endmodule

// File: tb/tb_click_classifier.sv
module tb_click_classifier;
   localparam int WINDOW = 10;
   localparam int NUM_MODES = 4;
   localparam int MODE_W = 2;

   typedef struct {
      int kind;   // 1 = single, 2 = double
      int cyc;
      int mode;
   } ev_t;

   logic clk;
   logic rst;
   int   cyc;
   int   n_tests;
   int   n_fail;
   ev_t  sb_q[$];

   click_classifier_if #(.MODE_W(MODE_W)) bus ();

   click_classifier #(.WINDOW(WINDOW), .NUM_MODES(NUM_MODES), .MODE_W(MODE_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic exp_ev(input int k, input int c, input int m);
      ev_t e;
      e.kind = k; e.cyc = c; e.mode = m;
      sb_q.push_back(e);
   endtask

   // press at the current negedge and again gap cycles later
   task automatic two_press(input int gap);
      bus.press = 1'b1;
      @(negedge clk) bus.press = 1'b0;
      repeat (gap - 1) @(negedge clk);
      bus.press = 1'b1;
      @(negedge clk) bus.press = 1'b0;
   endtask

   task automatic single_one(input int m);
      int t0;
      t0 = cyc;
      exp_ev(1, t0 + WINDOW + 1, m);
      bus.press = 1'b1;
      @(negedge clk) bus.press = 1'b0;
      repeat (WINDOW + 4) @(negedge clk);
   endtask

   task automatic dbl(input int gap);
      int t0;
      t0 = cyc;
      exp_ev(2, t0 + gap + 1, 0);
      two_press(gap);
      repeat (4) @(negedge clk);
   endtask

   // monitor: every event the DUT presents is checked against the scoreboard
   always @(negedge clk) begin
      if (rst && (bus.single_click || bus.double_click)) begin
         ev_t e;
         int  k;
         if (bus.single_click && bus.double_click) begin
            n_tests++; n_fail++;
            $display("FAIL both_pulses: single=1 double=1 expected one-hot (cycle %0d)", cyc);
         end
         k = bus.double_click ? 2 : 1;
         if (sb_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_event: got kind %0d expected none (cycle %0d)", k, cyc);
         end else begin
            e = sb_q.pop_front();
            chk("ev_kind", k, e.kind);
            chk("ev_cycle", cyc, e.cyc);
            chk("ev_mode", int'(bus.mode), e.mode);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0;
      n_tests = 0;
      n_fail  = 0;
      bus.press = 1'b0;
      rst = 1'b0;

      // reset
      repeat (3) @(negedge clk);
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_mode", int'(bus.mode), 0);
      rst = 1'b1;
      @(negedge clk);
      chk("post_rst_busy", int'(bus.busy), 0);
      chk("post_rst_single", int'(bus.single_click), 0);
      chk("post_rst_double", int'(bus.double_click), 0);
      chk("post_rst_mode", int'(bus.mode), 0);

      // single click with busy profile
      t0 = cyc;
      exp_ev(1, t0 + 11, 1);
      bus.press = 1'b1;
      @(negedge clk) bus.press = 1'b0;
      for (int i = 1; i <= 11; i++) begin
         chk("single_busy", int'(bus.busy), 1);
         @(negedge clk);
      end
      chk("single_busy_end", int'(bus.busy), 0);
      chk("single_mode_hold", int'(bus.mode), 1);
      repeat (3) @(negedge clk);

      // double click, gap 5
      t0 = cyc;
      exp_ev(2, t0 + 6, 0);
      two_press(5);
      @(negedge clk);
      chk("double_busy_end", int'(bus.busy), 0);
      chk("double_mode", int'(bus.mode), 0);
      repeat (3) @(negedge clk);

      // press at the last window cycle still makes a double
      dbl(10);

      // press landing in SINGLE is ignored, no further event
      t0 = cyc;
      exp_ev(1, t0 + 11, 1);
      two_press(11);
      chk("ignored_busy", int'(bus.busy), 0);
      repeat (WINDOW + 4) @(negedge clk);
      chk("ignored_mode", int'(bus.mode), 1);

      // mode wrap from 0: 1,2,3,0 then up to 2 and double clears
      dbl(3);
      single_one(1);
      single_one(2);
      single_one(3);
      single_one(0);
      single_one(1);
      single_one(2);
      dbl(4);

      // reset mid-window
      single_one(1);
      bus.press = 1'b1;
      @(negedge clk) bus.press = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("midrst_busy", int'(bus.busy), 0);
      chk("midrst_mode", int'(bus.mode), 0);
      chk("midrst_single", int'(bus.single_click), 0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (WINDOW + 2) @(negedge clk);
      chk("midrst_quiet", int'(bus.busy), 0);
      single_one(1);

      chk("sb_drain", sb_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/click_classifier.md
Name: click_classifier

Overview:
- Consumes the single-cycle debounced press pulse produced by the button-debounce FSM.
- Classifies each press as a single click or a double click using a time window.
- Emits one-cycle event pulses and maintains a wrap-around mode register for the board's control logic.
- Runs in the 25 MHz system clock domain; its outputs feed mode-select and display logic.

Parameters:
- WINDOW, 5000000, double-click window in clk cycles (200 ms at 25 MHz); must be ≥ 2.
- NUM_MODES, 4, number of modes cycled by single clicks; must be ≥ 2.
- MODE_W, 2, width of mode output; must satisfy 2^MODE_W ≥ NUM_MODES.

Ports:
- clk  input  1  25 MHz system clock.
- rst  input  1  asynchronous reset, active-low (asserted when 0).
- press  input  1  debounced press pulse, one cycle wide, synchronous to clk.
- single_click  output  1  one-cycle pulse: a single click has been classified.
- double_click  output  1  one-cycle pulse: a double click has been classified.
- mode  output  MODE_W  current mode index, 0..NUM_MODES-1.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset: rst=0 asynchronously forces state=IDLE, window counter=0, mode=0, single_click=0, double_click=0, busy=0. This holds from any state, including mid-window; no event is emitted for an interrupted sequence.
- States: IDLE, WAIT, SINGLE, DOUBLE. All edges below are rising edges of clk with rst=1.
- IDLE: press=1 → WAIT, counter cleared to 0. Otherwise stay in IDLE.
- WAIT:
  - press=1 → DOUBLE.
  - Else if counter==WINDOW-1 → SINGLE.
  - Else counter increments by 1.
  - press has priority over timeout in the same cycle.
- SINGLE: lasts exactly one cycle, then → IDLE. A press arriving in this cycle is ignored.
- DOUBLE: lasts exactly one cycle, then → IDLE. A press arriving in this cycle is ignored.
- Outputs are Moore-decoded from the state register (no combinational path from press):
  - single_click = (state==SINGLE)
  - double_click = (state==DOUBLE)
  - busy = (state!=IDLE)
- Mode register:
  - Updates on the same edge that enters SINGLE or DOUBLE, so the new value is visible in the same cycle as the pulse.
  - Entering SINGLE: mode ← mode+1, wrapping from NUM_MODES-1 to 0.
  - Entering DOUBLE: mode ← 0.
  - Otherwise mode holds.
- Latency:
  - Single click: press in cycle 0 → single_click high in cycle WINDOW+1.
  - Double click: first press in cycle 0, second press in cycle p (1 ≤ p ≤ WINDOW) → double_click high in cycle p+1.
- Counter width: clog2(WINDOW). The counter never exceeds WINDOW-1 and is only meaningful in WAIT.
- single_click and double_click are never high in the same cycle. At most one event is produced per first press.
- A third press after DOUBLE (once back in IDLE) starts a fresh classification.

Test Plan (WINDOW=10, NUM_MODES=4):
- Reset: hold rst=0 for 3 cycles, then release → all outputs 0, mode=0, busy=0.
- Single click: press in cycle 0 → busy=1 in cycles 1–11; single_click=1 only in cycle 11; mode=1 from cycle 11; no double_click.
- Double click: press in cycles 0 and 5 → double_click=1 in cycle 6; mode=0; no single_click at any time; busy=0 from cycle 7.
- Boundary, press vs timeout: press in cycles 0 and 10 → double_click in cycle 11. Separately, press in cycles 0 and 11 → single_click in cycle 11, the cycle-11 press is ignored, and no further event follows.
- Mode wrap: four isolated single clicks → mode sequence 1, 2, 3, 0. Then a double click from mode=2 → mode=0.
- Reset mid-operation: press in cycle 0, rst=0 in cycle 5 → state IDLE immediately (asynchronous), no pulse ever emitted, mode=0. A press after release classifies normally.
